// File: rtl/hps_cmd_pkg.sv
// Shared constants for the HPS command queue: default geometry, control bits
// and status word layout.
package hps_cmd_pkg;
    localparam int FIELD_W_DEF    = 8;
    localparam int NUM_FIELDS_DEF = 6;
    localparam int REC_W          = (NUM_FIELDS_DEF + 1) * FIELD_W_DEF;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    // Status flags sit at the top of the read word, counted down from the MSB.
    localparam int STAT_OVF_OFS   = 1;
    localparam int STAT_FULL_OFS  = 2;
    localparam int STAT_EMPTY_OFS = 3;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk50) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk50) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/hps_cmd_queue.sv
// HPS register front end: staging fields, atomic commit into a record FIFO,
// flush/overflow control and a registered status readback.
module hps_cmd_queue
    import hps_cmd_pkg::*;
#(
    parameter int NUM_FIELDS  = NUM_FIELDS_DEF,
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int ADDR_W      = 3,
    parameter int DEPTH       = 16,
    parameter int COMMIT_ADDR = NUM_FIELDS,
    parameter int CTRL_ADDR   = NUM_FIELDS + 1,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int REC  = (NUM_FIELDS + 1) * FIELD_W
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               hps_chipselect,
    input  logic               hps_write,
    input  logic               hps_read,
    input  logic [ADDR_W-1:0]  hps_address,
    input  logic [FIELD_W-1:0] hps_writedata,
    output logic [FIELD_W-1:0] hps_readdata,
    // Record handshake: a record transfers on every edge where out_valid and
    // out_ready are both high; out_data is stable while out_valid waits.
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REC-1:0]     out_data,
    output logic [CW-1:0]      out_count
);
    logic [FIELD_W-1:0]            fields [NUM_FIELDS];
    logic [NUM_FIELDS*FIELD_W-1:0] fields_flat;
    logic [FIELD_W-1:0]            status;
    logic                          overflow;
    logic                          wr_en;
    logic                          rd_en;
    logic                          commit;
    logic                          ctrl_wr;
    logic                          flush;
    logic                          drop;
    logic                          fifo_full;
    logic                          fifo_empty;

    assign wr_en   = hps_chipselect && hps_write;
    assign rd_en   = hps_chipselect && hps_read;
    assign commit  = wr_en && (hps_address == ADDR_W'(COMMIT_ADDR));
    assign ctrl_wr = wr_en && (hps_address == ADDR_W'(CTRL_ADDR));
    assign flush   = ctrl_wr && hps_writedata[CTRL_FLUSH];
    assign drop    = commit && fifo_full && !out_ready;

    always_comb begin
        fields_flat = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            fields_flat[i*FIELD_W +: FIELD_W] = fields[i];
        end
    end

    always_comb begin
        status                           = '0;
        status[FIELD_W-STAT_OVF_OFS]     = overflow;
        status[FIELD_W-STAT_FULL_OFS]    = fifo_full;
        status[FIELD_W-STAT_EMPTY_OFS]   = fifo_empty;
        status[CW-1:0]                   = out_count;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) fields[i] <= '0;
            overflow     <= 1'b0;
            hps_readdata <= '0;
        end else begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (wr_en && hps_address == ADDR_W'(i)) fields[i] <= hps_writedata;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && hps_writedata[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
            if (rd_en) hps_readdata <= status;
        end
    end

    sync_fifo #(
        .WIDTH (REC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk50 (clk50),
        .reset (reset),
        .flush (flush),
        .push  (commit),
        .pop   (out_ready),
        .wdata ({hps_writedata, fields_flat}),
        .rdata (out_data),
        .count (out_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
endmodule

// File: tb/tb_hps_cmd_queue.sv
// Directed bench for hps_cmd_queue: a vector table for the single-cycle
// register behaviour plus hand sequences for fill, overflow, flush and reset.
module tb_hps_cmd_queue;
    logic        clk50 = 1'b0;
    logic        reset;
    logic        hps_chipselect;
    logic        hps_write;
    logic        hps_read;
    logic [2:0]  hps_address;
    logic [7:0]  hps_writedata;
    logic [7:0]  hps_readdata;
    logic        out_valid;
    logic        out_ready;
    logic [55:0] out_data;
    logic [4:0]  out_count;

    int checks   = 0;
    int failures = 0;
    logic [55:0] exp_q[$];

    localparam logic [47:0] F_BASE = 48'h0000_FFFF_FFFD;
    localparam logic [47:0] F_MOD  = 48'h0000_FF3C_FFFD;

    typedef struct {
        logic [1:0]  op;      // 0 idle, 1 write, 2 read
        logic [2:0]  addr;
        logic [7:0]  wdata;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_count;
        logic        chk_head;
        logic [55:0] exp_head;
        logic        chk_rd;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[15];

    hps_cmd_queue dut (
        .clk50          (clk50),
        .reset          (reset),
        .hps_chipselect (hps_chipselect),
        .hps_write      (hps_write),
        .hps_read       (hps_read),
        .hps_address    (hps_address),
        .hps_writedata  (hps_writedata),
        .hps_readdata   (hps_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        hps_chipselect = 1'b1;
        hps_write      = 1'b1;
        hps_address    = a;
        hps_writedata  = d;
        @(negedge clk50);
        hps_chipselect = 1'b0;
        hps_write      = 1'b0;
    endtask

    task automatic bus_read();
        hps_chipselect = 1'b1;
        hps_read       = 1'b1;
        @(negedge clk50);
        hps_chipselect = 1'b0;
        hps_read       = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget < 100) begin
            if (out_valid) check(name, out_data, exp_q.pop_front());
            @(negedge clk50);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d expected=0 records left", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_empty_valid"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'd1, 3'd0, 8'hFD, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[1]  = '{2'd1, 3'd1, 8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[2]  = '{2'd1, 3'd2, 8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[3]  = '{2'd1, 3'd3, 8'hFF, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[4]  = '{2'd1, 3'd4, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[5]  = '{2'd1, 3'd5, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[6]  = '{2'd1, 3'd7, 8'hEE, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[7]  = '{2'd1, 3'd6, 8'h07, 1'b0, 1'b1, 5'd1, 1'b1, {8'h07, F_BASE}, 1'b0, 8'h0};
        vecs[8]  = '{2'd2, 3'd3, 8'h00, 1'b0, 1'b1, 5'd1, 1'b1, {8'h07, F_BASE}, 1'b1, 8'h01};
        vecs[9]  = '{2'd1, 3'd2, 8'h3C, 1'b0, 1'b1, 5'd1, 1'b1, {8'h07, F_BASE}, 1'b0, 8'h0};
        vecs[10] = '{2'd1, 3'd6, 8'h07, 1'b0, 1'b1, 5'd2, 1'b1, {8'h07, F_BASE}, 1'b0, 8'h0};
        vecs[11] = '{2'd0, 3'd0, 8'h00, 1'b1, 1'b1, 5'd1, 1'b1, {8'h07, F_MOD}, 1'b0, 8'h0};
        vecs[12] = '{2'd0, 3'd0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};
        vecs[13] = '{2'd2, 3'd0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 56'h0, 1'b1, 8'h20};
        vecs[14] = '{2'd0, 3'd0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 56'h0, 1'b0, 8'h0};

        // clock/reset
        reset = 1'b1; hps_chipselect = 1'b0; hps_write = 1'b0; hps_read = 1'b0;
        hps_address = '0; hps_writedata = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        check("reset_valid", out_valid, 1'b0);
        check("reset_count", out_count, 5'd0);
        check("reset_readdata", hps_readdata, 8'h00);

        // table: basic commit, ignored address, field persistence, read latency
        for (int i = 0; i < 15; i++) begin
            out_ready      = vecs[i].ready;
            hps_address    = vecs[i].addr;
            hps_writedata  = vecs[i].wdata;
            hps_chipselect = (vecs[i].op != 2'd0);
            hps_write      = (vecs[i].op == 2'd1);
            hps_read       = (vecs[i].op == 2'd2);
            @(negedge clk50);
            hps_chipselect = 1'b0; hps_write = 1'b0; hps_read = 1'b0;
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_count", i), out_count, vecs[i].exp_count);
            if (vecs[i].chk_head) check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_head);
            if (vecs[i].chk_rd)   check($sformatf("vec%0d_rd", i), hps_readdata, vecs[i].exp_rd);
        end
        out_ready = 1'b0;

        // fill to 16 and overflow with tag 16
        for (int t = 0; t < 17; t++) begin
            bus_write(3'd6, 8'(t));
            if (t < 16) exp_q.push_back({8'(t), F_MOD});
        end
        check("fill_count", out_count, 5'd16);
        bus_read();
        check("fill_status", hps_readdata, 8'hD0);
        drain("fill_drain");

        // full with simultaneous pop
        bus_write(3'd7, 8'h02);
        for (int t = 16; t < 32; t++) begin
            bus_write(3'd6, 8'(t));
            exp_q.push_back({8'(t), F_MOD});
        end
        check("fullpop_head", out_data, exp_q.pop_front());
        out_ready = 1'b1;
        bus_write(3'd6, 8'hAA);
        out_ready = 1'b0;
        exp_q.push_back({8'hAA, F_MOD});
        check("fullpop_count", out_count, 5'd16);
        bus_read();
        check("fullpop_status", hps_readdata, 8'h50);
        drain("fullpop_drain");

        // flush and clear overflow
        for (int t = 0; t < 17; t++) bus_write(3'd6, 8'(t));
        bus_write(3'd7, 8'h01);
        check("flush1_count", out_count, 5'd0);
        for (int t = 0; t < 5; t++) bus_write(3'd6, 8'(t + 64));
        check("five_count", out_count, 5'd5);
        out_ready = 1'b1;
        bus_write(3'd7, 8'h01);
        out_ready = 1'b0;
        check("flush2_valid", out_valid, 1'b0);
        check("flush2_count", out_count, 5'd0);
        bus_read();
        check("flush2_status", hps_readdata, 8'hA0);
        bus_write(3'd7, 8'h02);
        bus_read();
        check("clrovf_status", hps_readdata, 8'h20);
        bus_write(3'd6, 8'h55);
        check("postflush_valid", out_valid, 1'b1);
        check("postflush_data", out_data, {8'h55, F_MOD});

        // reset mid-stream with a pop in progress
        bus_write(3'd6, 8'h56);
        bus_write(3'd6, 8'h57);
        check("pre_reset_count", out_count, 5'd3);
        out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk50);
        reset = 1'b0;
        out_ready = 1'b0;
        check("midreset_valid", out_valid, 1'b0);
        check("midreset_count", out_count, 5'd0);
        check("midreset_readdata", hps_readdata, 8'h00);
        bus_write(3'd6, 8'h99);
        check("midreset_fields", out_data, {8'h99, 48'h0});
        check("midreset_newcount", out_count, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hps_cmd_queue.md
Name: hps_cmd_queue

Overview:
- Parametrised successor to the HPS byte-register interface of the sprite/render path.
- HPS writes NUM_FIELDS staging bytes, then writes to COMMIT_ADDR with a tag byte. This atomically pushes one packed command record into an internal FIFO.
- The renderer drains records over a valid/ready handshake.
- Adds buffering, overflow detection, flush, and a status readback that the single-entry register scheme lacks.

Parameters:
- NUM_FIELDS, 6, number of staging field registers (addresses 0..NUM_FIELDS-1).
- FIELD_W, 8, width of hps_writedata/hps_readdata and of each field.
- ADDR_W, 3, hps_address width; must satisfy NUM_FIELDS+2 <= 2**ADDR_W.
- DEPTH, 16, FIFO entries; power of two, >= 2; clog2(DEPTH+1) <= FIELD_W-3.
- COMMIT_ADDR, NUM_FIELDS, address whose write pushes a record.
- CTRL_ADDR, NUM_FIELDS+1, control register address.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- hps_chipselect  in  1  bus select.
- hps_write  in  1  write strobe; a write is accepted when chipselect&&write.
- hps_read  in  1  read strobe; a read is accepted when chipselect&&read.
- hps_address  in  ADDR_W  register address.
- hps_writedata  in  FIELD_W  write data.
- hps_readdata  out  FIELD_W  status word, registered.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_data  out  (NUM_FIELDS+1)*FIELD_W  record {tag, field[NUM_FIELDS-1], ..., field[0]}; field[0] occupies the LSBs.
- out_count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - All staging fields, FIFO pointers, count, overflow flag, out_valid and hps_readdata go to 0.
  - out_data is don't-care while out_valid=0.
  - Reset mid-operation discards all queued records and staging contents.
- Write to addr a < NUM_FIELDS: field[a] <= writedata at the next edge.
  - Fields persist across commits; repeated commits reuse unchanged fields.
- Write to COMMIT_ADDR builds record {writedata, field[]}.
  - Staging writes in the same cycle are impossible (single bus), so the record always uses the field values held before that edge.
- Push decision:
  - count<DEPTH: push.
  - count==DEPTH and out_ready=1 (pop this cycle): push accepted; count unchanged.
  - count==DEPTH and out_ready=0: record dropped; overflow<=1 (sticky).
- Pop: out_valid && out_ready advances the read pointer. out_ready while empty is ignored.
- Latency:
  - A record committed into an empty queue appears on out_valid/out_data at the edge after the commit (1 cycle). There is no combinational bypass.
  - out_data equals the FIFO head at all times while out_valid=1 and holds stable until popped.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- CTRL_ADDR write:
  - bit0 = flush: count<=0, pointers<=0, out_valid<=0.
  - bit1 = clear overflow.
  - Other bits are ignored.
  - Flush is exclusive with a commit (single bus). A pop in the flush cycle is absorbed: count becomes 0 regardless.
- Writes to addresses > CTRL_ADDR are ignored.
- Read: hps_readdata <= {overflow, full, empty, zero-pad, count} one cycle after an accepted read, from any address.
  - full = count==DEPTH; empty = count==0. Bits are packed MSB-first; count is in the LSBs.
  - hps_readdata holds its value between reads.

Decomposition:
- Package hps_cmd_pkg holds:
  - default FIELD_W and NUM_FIELDS;
  - localparam REC_W;
  - CTRL bit indices (CTRL_FLUSH=0, CTRL_CLR_OVF=1);
  - status bit positions.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - ports clk50, reset, flush, push, pop, wdata, rdata, count, full, empty;
  - registered storage; push-while-full-with-pop allowed.
- hps_cmd_queue contains the register decode, staging, overflow and status logic, and instantiates sync_fifo.

Test Plan:
- Basic commit: write fields 0..5 = FD,FF,FF,FF,00,00, then COMMIT tag 07, out_ready=0. Expect: one cycle later out_valid=1, out_data=0x07_00_00_FF_FF_FF_FD, out_count=1.
- Fill and overflow: 17 commits with tags 0..16, out_ready=0, DEPTH=16. Expect count=16; status read gives full=1, overflow=1. Draining yields tags 0..15 in order; tag 16 is absent.
- Full with simultaneous pop: queue full, commit tag AA while out_ready=1. Expect count stays 16, overflow=0, and AA is the last record drained.
- Flush and clear: 5 records queued with overflow set. CTRL write 0x01 gives out_valid=0, count=0, overflow still 1. CTRL write 0x02 clears overflow. A new commit then appears with latency 1.
- Field persistence and read latency: commit, change only field 2 to 3C, commit again. Expect the second record differs from the first only in byte 2. A status read returns its value on the following cycle.
- Reset mid-stream: 3 records queued and a pop in progress, assert reset for 1 cycle. Expect out_valid=0, count=0, fields=0, readdata=0 on the next edge.
